// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, 1 stop bit.
// Oversamples the line, validates the frame and writes good bytes to a byte RAM.
// A 0x00 byte terminates a message: done pulses and the address restarts at 0.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              done,
  output logic              parity_err,
  output logic              frame_err,
  output logic              idle
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              rx_meta_q, rx_s_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;

  // Two-flop synchronizer; idle-high so reset does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame state, counters and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state decode; every sample is taken at the middle of its bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    // Address advances the cycle after a write; a terminator restarts the message.
    addr_d = addr_q;
    if (wr_en_q) begin
      addr_d = done_q ? '0 : addr_q + ADDR_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
          bit_d   = '0;
          par_d   = 1'b0;
        end
      end
      StStart: begin
        if (cnt_q == CntMid) begin
          cnt_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s_q;
          par_d          = par_q ^ rx_s_q;
          if (bit_q == 3'd7) begin
            state_d = StParity;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          par_d   = par_q ^ rx_s_q;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            // Framing error masks any parity error in the same frame.
            ferr_d  = 1'b1;
            state_d = StBreak;
          end else if (par_q) begin
            perr_d  = 1'b1;
            state_d = StIdle;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = shift_q;
            done_d    = (shift_q == 8'h00);
            state_d   = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBreak: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign wr_addr    = addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign done       = done_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign idle       = (state_q == StIdle);

endmodule
